// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and select-width helper for nway_mux_arb.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nway_mux_arb_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant, searching upward from ptr+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    always_comb begin
        int           idx;
        logic [N-1:0] w_rot;
        idx         = 0;
        w_rot       = '0;
        grant       = '0;
        grant_valid = 1'b0;
        // Farthest offset first so the nearest requester after ptr overwrites it.
        for (int k = N; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % N;
            w_rot = req >> idx;
            if (w_rot[0]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nway_mux_arb.sv
// ============================================================================
// Module   : nway_mux_arb
// Purpose  : N-way channel mux with fixed/round-robin arbitration feeding a
//            one-entry registered output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nway_mux_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  src_q, src_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             w_load_en;
    logic             w_fix_valid;
    logic [SELW-1:0]  w_rr_grant;
    logic             w_rr_valid;
    logic [SELW-1:0]  w_grant;
    logic             w_grant_valid;
    logic [WIDTH-1:0] w_grant_data;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_valid)
    );

    assign w_load_en = (state_q == ST_EMPTY) | out_ready;

    // A sel value beyond the last channel matches no index and yields no grant.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                w_fix_valid = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = sel;
            w_grant_valid = w_fix_valid;
        end
    end

    always_comb begin
        w_grant_data = '0;
        in_ready     = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
                in_ready[i]  = !reset && w_load_en && w_grant_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (w_load_en) begin
            if (w_grant_valid) begin
                state_d = ST_FULL;
                data_d  = w_grant_data;
                src_d   = w_grant;
                if (mode == MODE_RR) begin
                    ptr_d = w_grant;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // ptr resets to the last channel so the first round-robin search begins at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

`default_nettype wire

// File: tb/tb_nway_mux_arb.sv
// ============================================================================
// Module   : tb_nway_mux_arb
// Purpose  : Self-checking bench for nway_mux_arb (N=4 main instance, N=3 side).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nway_mux_arb;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int N3 = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [S-1:0]   sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [S-1:0]   out_src;

    logic [N3*W-1:0] in_data3;
    logic [N3-1:0]   in_valid3;
    logic [N3-1:0]   in_ready3;
    logic [S-1:0]    sel3;
    logic [W-1:0]    out_data3;
    logic            out_valid3;
    logic            out_ready3;
    logic [S-1:0]    out_src3;

    nway_mux_arb #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    nway_mux_arb #(.WIDTH(W), .N(N3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_src   (out_src3)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference state of the N=4 instance: what the output register should hold.
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic tick();
        bit           le;
        bit           gv;
        int           g;
        int           c;
        logic [N-1:0] er;
        logic [N-1:0] t;
        logic [W-1:0] gd;
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_src",   32'(out_src),   32'(m_src));
        le = !m_valid || out_ready;
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            t = in_valid >> sel;
            if (int'(sel) < N && t[0]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 1; k <= N && !gv; k++) begin
                c = (m_ptr + k) % N;
                t = in_valid >> c;
                if (t[0]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
        er = '0;
        if (!reset && le && gv) er = N'(1) << g;
        chk("in_ready", 32'(in_ready), 32'(er));
        gd = W'(in_data >> (g * W));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = N - 1;
        end else if (le) begin
            if (gv) begin
                m_valid = 1'b1;
                m_data  = gd;
                m_src   = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] held;

        reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; sel3 = '0; out_ready3 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = N - 1;
        in_valid = 4'b1111;
        tick();
        tick();

        // Fixed select of channel 1 with every channel offering its own index.
        reset = 1'b0; mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("fix_data", 32'(out_data), 32'h0001);
            chk("fix_src",  32'(out_src),  32'd1);
        end

        // Round-robin from reset: sources 0,1,2,3,0 back to back.
        reset = 1'b1; tick();
        reset = 1'b0; mode = 1'b1; in_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_seq_src",   32'(out_src),   32'(n % N));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Sparse requesters with ptr at 1: grants alternate 3,1,3.
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 4'b0010; tick();
        in_valid = 4'b1010;
        tick(); chk("rr_sparse0", 32'(out_src), 32'd3);
        tick(); chk("rr_sparse1", 32'(out_src), 32'd1);
        tick(); chk("rr_sparse2", 32'(out_src), 32'd3);

        // Backpressure for three cycles, then release.
        in_valid = 4'b1111;
        tick();
        held = out_data;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_data = {$urandom, $urandom};
            tick();
            chk("bp_hold_data",  32'(out_data),  32'(held));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        tick();

        // Reset while holding 16'hBEEF, then first round-robin grant goes to channel 0.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2*W +: W] = 16'hBEEF;
        tick();
        chk("beef_loaded", 32'(out_data), 32'hBEEF);
        out_ready = 1'b0; reset = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_src",   32'(out_src),   32'd0);
        reset = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        tick();
        chk("rst_first_rr", 32'(out_src), 32'd0);

        // N=3 instance: an out-of-range select grants nothing and the output drains.
        mode = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {16'h0CC2, 16'h0CC1, 16'h0CC0};
        tick();
        chk("n3_load_valid", 32'(out_valid3), 32'd1);
        chk("n3_load_data",  32'(out_data3),  32'h0CC1);
        sel3 = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(in_ready3), 32'd0);
        tick();
        chk("n3_drain_valid", 32'(out_valid3), 32'd0);
        chk("n3_drain_ready", 32'(in_ready3),  32'd0);
        in_valid3 = '0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nway_mux_arb.md
NWAY_MUX_ARB -- requirements
Module: nway_mux_arb

Interface
REQ-001 Parameter WIDTH, default 16: data width of every input channel and of the output.
REQ-002 Parameter N, default 4: number of input channels, minimum 2; SELW = max(1, ceil(log2 N)).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  N  per-channel valid; channel i offers a word when in_valid[i]=1.
REQ-007 in_ready  output  N  per-channel ready; a transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1.
REQ-008 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-009 sel  input  SELW  channel index used in fixed-select mode.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both 1.
REQ-013 out_src  output  SELW  index of the channel that supplied out_data.

Function
REQ-014 Output stage is a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load_en = !out_valid | out_ready; a new word is captured only in a cycle where load_en=1.
REQ-016 Fixed mode: grant is channel sel when sel<N and in_valid[sel]=1; otherwise there is no grant.
REQ-017 Round-robin mode: grant is the first channel with in_valid=1, searching from (ptr+1) mod N upward with wrap-around; if no channel is valid, there is no grant.
REQ-018 in_ready[i] = load_en & (grant==i); all other in_ready bits are 0, so at most one bit is 1 per cycle.
REQ-019 in_ready is combinational from in_valid, mode, sel, out_valid and out_ready; in_ready[i] does not depend on in_data.
REQ-020 On a transfer, out_data, out_src and out_valid=1 are updated at the next edge (latency 1 cycle).
REQ-021 If load_en=1 and there is no grant, out_valid clears to 0 at the next edge; out_data and out_src hold their values.
REQ-022 When out_valid=1 and out_ready=1 and a new grant exists in the same cycle, the old word is consumed and the new word loads with no bubble, giving 1 word/cycle throughput.
REQ-023 When out_valid=1 and out_ready=0, out_data, out_src and out_valid are held stable and all in_ready bits are 0.
REQ-024 ptr updates to the granted index on every round-robin transfer only; fixed-mode transfers leave ptr unchanged.
REQ-025 A change of mode or sel takes effect in the same cycle's grant computation; ptr is preserved across mode changes.
REQ-026 sel >= N, possible when N is not a power of 2, produces no grant; this is not an error condition.

Reset
REQ-027 In a reset cycle: out_valid=0, out_data=0, out_src=0, ptr=N-1 (so round-robin priority starts at channel 0).
REQ-028 Reset takes priority over any transfer in the same cycle; a word pending or in flight is discarded.
REQ-029 While reset=1, in_ready shall be all 0.

Structure
REQ-030 Package mux_pkg holds the MODE_FIXED=0 and MODE_RR=1 constants and the SELW derivation function.
REQ-031 Round-robin grant logic is a sub-module rr_arbiter (inputs req[N] and ptr; outputs grant index and grant_valid), instantiated once.
REQ-032 The block contains no other storage than the output register, out_src and ptr.

Verification
REQ-033 Fixed mode, N=4, sel=1, in_valid=4'b1111, channel i data = 16'h000i, out_ready=1 -> out_data=16'h0001 and out_src=1 every cycle, in_ready=4'b0010.
REQ-034 Round-robin mode with all channels valid, out_ready=1, starting after reset -> out_src sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-035 Round-robin mode, in_valid=4'b1010, ptr=1 -> grant to 3, then to 1, then to 3; channels 0 and 2 are never granted.
REQ-036 Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data held, in_ready=0 throughout; the word is consumed on the first cycle out_ready=1.
REQ-037 Reset asserted while FULL with out_data=16'hBEEF -> next edge out_valid=0, out_data=0, out_src=0; the first round-robin grant afterwards goes to channel 0.
REQ-038 Fixed mode with N=3 and sel=3 -> no grant, in_ready=0, out_valid drains to 0.
